// File: rtl/bram_stream_reader.sv
// Read engine for the 36x512 simple dual-port line buffer: takes (addr, len) commands, drives the
// buffer read port and returns words as a valid/ready stream. Define BRAM_STREAM_READER_ABORT_EN for the abort port.
module bram_stream_reader #(
  parameter int DW = 36,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
`ifdef BRAM_STREAM_READER_ABORT_EN
  input  logic          abort,
`endif
  output logic          rd_ce,
  output logic          rd_oce,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_addr_q;
  logic [AW:0]   remaining_q;
  logic          inflight_q;
  logic          inflight_last_q;
  logic [1:0]    fifo_cnt_q;
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [DW:0]   fifo_mem_q [2];
  logic          done_q;

  logic          accept;
  logic          push;
  logic          pop;
  logic          head_last;
  logic [DW:0]   head;
  logic          last_issue;
  logic          abort_act;
  logic          credit_ok;
  logic [1:0]    occupancy;
  logic [1:0]    occupancy_after_pop;

`ifdef BRAM_STREAM_READER_ABORT_EN
  assign abort_act = abort && (state_q != S_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // FIFO head and stream side
  assign head      = fifo_mem_q[rd_ptr_q];
  assign head_last = head[DW];
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = head[DW-1:0];
  assign out_last  = out_valid && head_last;
  assign push      = inflight_q;
  assign pop       = out_valid && out_ready;

  // Credit counts the slot freed by a same-cycle pop so a steady one-word-per-clock flow never stalls.
  assign occupancy           = fifo_cnt_q + {1'b0, inflight_q};
  assign occupancy_after_pop = occupancy - {1'b0, pop};
  assign credit_ok           = (occupancy_after_pop < 2'd2);

  assign accept     = cmd_valid && cmd_ready;
  assign last_issue = rd_ce && (remaining_q == (AW+1)'(1));

  assign rd_oce  = 1'b1;
  assign rd_addr = rd_addr_q;
  assign done    = done_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)             state_d = S_RUN;
      S_RUN:   if (last_issue)         state_d = S_DRAIN;
      S_DRAIN: if (pop && head_last)   state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
    if (abort_act) begin
      state_d = S_IDLE;
    end
  end

  // Output logic
  always_comb begin
    cmd_ready = 1'b0;
    rd_ce     = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready = !reset;
        busy      = 1'b0;
      end
      S_RUN:   rd_ce = credit_ok && !abort_act && !reset;
      S_DRAIN: rd_ce = 1'b0;
      default: busy  = 1'b0;
    endcase
  end

  // Read issue, in-flight tracking and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q       <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_cnt_q      <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q <= ((state_q == S_DRAIN) && pop && head_last) || abort_act;

      if (accept) begin
        rd_addr_q   <= cmd_addr;
        remaining_q <= {1'b0, cmd_len} + (AW+1)'(1);
      end else if (rd_ce) begin
        rd_addr_q   <= rd_addr_q + AW'(1);
        remaining_q <= remaining_q - (AW+1)'(1);
      end

      inflight_q      <= rd_ce;
      inflight_last_q <= last_issue;

      if (abort_act) begin
        fifo_cnt_q <= 2'd0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
    end
  end

  // NOTE: FIFO storage carries no reset; fifo_cnt_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {inflight_last_q, rd_data};
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: models the line buffer, checks timing, order, credit and end-of-burst.
// Abort scenario compiled in only with BRAM_STREAM_READER_ABORT_EN.
module tb_bram_stream_reader;

  localparam int DW = 36;
  localparam int AW = 9;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
`ifdef BRAM_STREAM_READER_ABORT_EN
  logic          abort;
`endif
  logic          rd_ce;
  logic          rd_oce;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fails  = 0;

  bram_stream_reader #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
`ifdef BRAM_STREAM_READER_ABORT_EN
    .abort     (abort),
`endif
    .rd_ce     (rd_ce),
    .rd_oce    (rd_oce),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line buffer contents: low 9 bits equal the address, upper bits a scrambled tag.
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [26:0] h;
    h = ({18'b0, a} * 27'd4099) ^ 27'h2A5A5A5;
    return {h, a};
  endfunction

  logic [DW-1:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = word_of(AW'(i));
  end

  always @(posedge clk) begin
    if (rd_ce) rd_data <= mem[rd_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the command is taken on the next rising edge.
  task automatic issue_cmd(input logic [AW-1:0] addr, input logic [AW-1:0] len, input string tag);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    check({tag, " cmd_ready at issue"}, cmd_ready, 1'b1);
  endtask

  // mode 0: out_ready always high, 1: random 50%, 2: low for the first 7 cycles then high
  task automatic run_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len, input int mode,
                           input int budget, input string tag);
    int n, words, issued, lasts, outstanding, first_ce, first_val;
    logic [AW-1:0] iss_addr, exp_addr;
    logic pop, done_seen;
    n = int'(len) + 1;
    words = 0; issued = 0; lasts = 0; outstanding = 0; first_ce = -1; first_val = -1;
    iss_addr = addr;
    exp_addr = addr;
    done_seen = 1'b0;
    for (int k = 1; k <= budget && !done_seen; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k >= 8);
      endcase
      #1;
      pop = out_valid && out_ready;
      if (k == 1) begin
        check({tag, " busy after accept"}, busy, 1'b1);
        check({tag, " cmd_ready while busy"}, cmd_ready, 1'b0);
      end
      if (rd_ce) begin
        check({tag, " rd_addr"}, rd_addr, iss_addr);
        check({tag, " credit"}, (outstanding - int'(pop)) < 2, 1'b1);
        check({tag, " over-issue"}, issued < n, 1'b1);
        if (first_ce < 0) first_ce = k;
        iss_addr = iss_addr + AW'(1);
        issued++;
      end
      if (out_valid && first_val < 0) first_val = k;
      if (pop) begin
        check({tag, " out_data"}, out_data, word_of(exp_addr));
        check({tag, " out_last"}, out_last, (words == n - 1));
        if (mode == 0) check({tag, " handshake cycle"}, k, words + 3);
        if (out_last) lasts++;
        exp_addr = exp_addr + AW'(1);
        words++;
      end
      outstanding += int'(rd_ce) - int'(pop);
      if (done) begin
        done_seen = 1'b1;
        check({tag, " words at done"}, words, n);
        check({tag, " issues at done"}, issued, n);
        check({tag, " last count"}, lasts, 1);
        check({tag, " cmd_ready in done cycle"}, cmd_ready, 1'b1);
        check({tag, " busy in done cycle"}, busy, 1'b0);
        check({tag, " out_valid in done cycle"}, out_valid, 1'b0);
        if (mode == 0) begin
          check({tag, " done cycle"}, k, n + 3);
          check({tag, " first rd_ce cycle"}, first_ce, 1);
          check({tag, " first out_valid cycle"}, first_val, 3);
        end
      end
    end
    check({tag, " done within budget"}, done_seen, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
`ifdef BRAM_STREAM_READER_ABORT_EN
    abort     = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset cmd_ready", cmd_ready, 1'b0);
    check("reset rd_ce", rd_ce, 1'b0);
    check("reset rd_oce", rd_oce, 1'b1);
    check("reset rd_addr", rd_addr, 9'h000);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_last", out_last, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("cmd_ready after reset", cmd_ready, 1'b1);

    // Basic 4-word burst, then a back-to-back wrapping burst issued in the done cycle
    issue_cmd(9'h010, 9'd3, "A");
    run_burst(9'h010, 9'd3, 0, 50, "A");
    issue_cmd(9'h1FE, 9'd3, "B");
    run_burst(9'h1FE, 9'd3, 0, 50, "B");
    @(negedge clk);
    #1;
    check("done single pulse", done, 1'b0);

    // Single-word burst
    issue_cmd(9'h0C7, 9'd0, "C");
    run_burst(9'h0C7, 9'd0, 0, 50, "C");
    @(negedge clk);
    #1;
    check("C busy after done", busy, 1'b0);

    // Full 512-word burst under random backpressure
    issue_cmd(9'h123, 9'd511, "D");
    run_burst(9'h123, 9'd511, 1, 4000, "D");

    // Stall at start: FIFO fills to two and resumes
    @(negedge clk);
    #1;
    issue_cmd(9'h0A0, 9'd7, "E");
    run_burst(9'h0A0, 9'd7, 2, 100, "E");

    // Reset mid-burst
    @(negedge clk);
    #1;
    issue_cmd(9'h080, 9'd63, "R");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      out_ready = 1'b1;
    end
    #1;
    check("R busy before reset", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("R out_valid after reset", out_valid, 1'b0);
    check("R rd_ce after reset", rd_ce, 1'b0);
    check("R busy after reset", busy, 1'b0);
    check("R done after reset", done, 1'b0);
    check("R cmd_ready during reset", cmd_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("R cmd_ready after release", cmd_ready, 1'b1);
    check("R no done after release", done, 1'b0);
    issue_cmd(9'h1F0, 9'd20, "F");
    run_burst(9'h1F0, 9'd20, 0, 80, "F");

`ifdef BRAM_STREAM_READER_ABORT_EN
    begin
      int words;
      logic [AW-1:0] exp_addr;
      @(negedge clk);
      #1;
      issue_cmd(9'h100, 9'd99, "X");
      words = 0;
      exp_addr = 9'h100;
      for (int k = 1; k <= 100 && words < 10; k++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid && out_ready) begin
          check("X out_data", out_data, word_of(exp_addr));
          exp_addr = exp_addr + AW'(1);
          words++;
        end
        check("X no early done", done, 1'b0);
      end
      check("X ten words before abort", words, 10);
      @(negedge clk);
      abort = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        check("X out_data in abort cycle", out_data, word_of(exp_addr));
      end
      check("X rd_ce in abort cycle", rd_ce, 1'b0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("X out_valid after abort", out_valid, 1'b0);
      check("X done after abort", done, 1'b1);
      check("X cmd_ready after abort", cmd_ready, 1'b1);
      check("X busy after abort", busy, 1'b0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1;
        check("X rd_ce idle", rd_ce, 1'b0);
        check("X done once", done, 1'b0);
        check("X out_valid idle", out_valid, 1'b0);
      end
      issue_cmd(9'h033, 9'd5, "Y");
      run_burst(9'h033, 9'd5, 0, 50, "Y");
    end
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
